// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// The signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell; the serial adder evaluates it once per shift cycle.
module Full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sa_state_e        state_q;
   sa_state_e        state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-2:0] sum_sr_q;
   logic             carry_q;
   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] sum_final;

   Full_adder u_fa (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign accept = (state_q == IDLE) && start;
   assign last   = (state_q == SHIFT) && (cnt_q == LAST_BIT);
   // The shift register holds the WIDTH-1 lower bits; the bit being produced completes the word.
   assign sum_final = {fa_sum, sum_sr_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= '0;
         end else if (state_q == SHIFT) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Datapath registers carry no reset; they are always reloaded on an accepted start.
   always_ff @(posedge clk) begin
      if (accept) begin
         opa_q   <= a;
         opb_q   <= b;
         carry_q <= cin;
      end else if (state_q == SHIFT) begin
         opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
         opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
         carry_q <= fa_cout;
         for (int i = 0; i < WIDTH - 2; i++) begin
            sum_sr_q[i] <= sum_sr_q[i+1];
         end
         sum_sr_q[WIDTH-2] <= fa_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (last) begin
         sum  <= sum_final;
         cout <= fa_cout;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // On the last cycle carry_q is the carry into the MSB and fa_cout the carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (last) begin
         ovf <= carry_q ^ fa_cout;
      end
   end
`endif

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2 against an arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start2, cin2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;
   logic       ovf8, ovf2;

   int total = 0;
   int bad   = 0;

   logic [7:0] held8;
   logic       held_c8, held_o8;
   logic [1:0] held2;
   logic       held_c2, held_o2;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf8)
`endif
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .cin   (cin2),
      .busy  (busy2),
      .done  (done2),
      .sum   (sum2),
      .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf2)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf8 = 1'b0;
   assign ovf2 = 1'b0;
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signed overflow from two's-complement value ranges.
   function automatic logic signed_ovf(input int av, input int bv, input int c, input int w);
      int sa, sb, s;
      sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
      sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
      s  = sa + sb + c;
      return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
   endfunction

   task automatic check_ovf8(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 16'(ovf8), 16'(exp));
`endif
   endtask

   task automatic check_ovf2(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 16'(ovf2), 16'(exp));
`endif
   endtask

   task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] exp;
      exp = 9'(x) + 9'(y) + 9'(c);
      @(negedge clk);
      start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         check({tag, "_shift"}, 16'({busy8, done8, sum8, cout8}), 16'({2'b10, held8, held_c8}));
         check_ovf8({tag, "_shift"}, held_o8);
      end
      @(negedge clk);
      held8   = exp[7:0];
      held_c8 = exp[8];
      held_o8 = signed_ovf(int'(x), int'(y), int'(c), 8);
      check({tag, "_done"}, 16'({busy8, done8, sum8, cout8}), 16'({2'b01, held8, held_c8}));
      check_ovf8({tag, "_done"}, held_o8);
      @(negedge clk);
      check({tag, "_idle"}, 16'({busy8, done8, sum8, cout8}), 16'({2'b00, held8, held_c8}));
   endtask

   task automatic run2(input logic [1:0] x, input logic [1:0] y, input logic c);
      logic [2:0] exp;
      exp = 3'(x) + 3'(y) + 3'(c);
      @(negedge clk);
      start2 = 1'b1; a2 = x; b2 = y; cin2 = c;
      @(negedge clk);
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      check("w2_shift0", 16'({busy2, done2, sum2, cout2}), 16'({2'b10, held2, held_c2}));
      @(negedge clk);
      check("w2_shift1", 16'({busy2, done2, sum2, cout2}), 16'({2'b10, held2, held_c2}));
      @(negedge clk);
      held2   = exp[1:0];
      held_c2 = exp[2];
      held_o2 = signed_ovf(int'(x), int'(y), int'(c), 2);
      check("w2_done", 16'({busy2, done2, sum2, cout2}), 16'({2'b01, held2, held_c2}));
      check_ovf2("w2_done", held_o2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] exp, exp_next;
      logic [7:0] x, y;
      logic       c;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      held8 = '0; held_c8 = 1'b0; held_o8 = 1'b0;
      held2 = '0; held_c2 = 1'b0; held_o2 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset8", 16'({busy8, done8, sum8, cout8}), 16'h0);
      check("reset2", 16'({busy2, done2, sum2, cout2}), 16'h0);
      check_ovf8("reset8", 1'b0);
      rst = 1'b0;

      run8("t1", 8'h5A, 8'h3C, 1'b0);
      run8("t2a", 8'hFF, 8'h01, 1'b0);
      run8("t2b", 8'hFF, 8'h00, 1'b1);
      run8("t2c", 8'h80, 8'h80, 1'b0);
      run8("t2d", 8'h7F, 8'h00, 1'b1);
      for (int n = 0; n < 6; n++) begin
         run8("rand", 8'($urandom), 8'($urandom), 1'($urandom));
      end

      // start held high: one result every WIDTH+2 cycles, in-flight operands ignored
      @(negedge clk);
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      exp = 9'(x) + 9'(y) + 9'(c);
      start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("cont_done", 16'(done8), 16'(k == 8));
            if (k == 8) begin
               held8 = exp[7:0];
               held_c8 = exp[8];
               held_o8 = signed_ovf(int'(x), int'(y), int'(c), 8);
               check("cont_sum", 16'({sum8, cout8}), 16'({held8, held_c8}));
               check_ovf8("cont", held_o8);
            end
            if (k == 9) begin
               x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
               exp_next = 9'(x) + 9'(y) + 9'(c);
               a8 = x; b8 = y; cin8 = c;
               if (r == 2) start8 = 1'b0;
            end else begin
               a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
         end
         exp = exp_next;
      end

      // asynchronous reset during the third SHIFT cycle
      run8("pre_rst", 8'hC3, 8'h5A, 1'b1);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_async8", 16'({busy8, done8, sum8, cout8}), 16'h0);
      check("rst_async2", 16'({busy2, done2, sum2, cout2}), 16'h0);
      check_ovf8("rst_async8", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      held8 = '0; held_c8 = 1'b0; held_o8 = 1'b0;
      held2 = '0; held_c2 = 1'b0; held_o2 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("rst_nodone", 16'({busy8, done8, sum8, cout8}), 16'h0);
      end
      run8("post_rst", 8'h01, 8'h01, 1'b0);

      for (int n = 0; n < 32; n++) begin
         run2(2'(n), 2'(n >> 2), 1'(n >> 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
